// File: rtl/corr_host_bridge_pkg.sv
// Shared definitions for the correlator host bridge: register address map,
// FSM state encoding and configuration reset values.
package corr_pkg;

    localparam logic [6:0] CORR_ADDR_SEED    = 7'h00;
    localparam logic [6:0] CORR_ADDR_WLEN    = 7'h01;
    localparam logic [6:0] CORR_ADDR_WSHAPE  = 7'h02;
    localparam logic [6:0] CORR_ADDR_SPERIOD = 7'h03;
    localparam logic [6:0] CORR_ADDR_SJITTER = 7'h04;
    localparam logic [6:0] CORR_ADDR_PWM     = 7'h05;
    localparam logic [6:0] CORR_ADDR_FIFO    = 7'h06;
    localparam logic [6:0] CORR_ADDR_FLUSH   = 7'h07;
    localparam logic [6:0] CORR_ADDR_BURST   = 7'h08;
    localparam logic [6:0] CORR_ADDR_ID      = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRDATA = 2'd1,
        RDRESP = 2'd2,
        BURST  = 2'd3
    } corrState_t;

    localparam int RST_WINDOW_LENGTH_EXP = 10;
    localparam int RST_SAMPLE_PERIOD_EXP = 0;
    localparam int RST_SAMPLE_JITTER_EXP = 0;

    // Saturate a written exponent byte to the register's maximum.
    function automatic logic [7:0] clampByte(input logic [7:0] value, input int maxValue);
        return (int'(value) > maxValue) ? 8'(maxValue) : value;
    endfunction

endpackage

// File: rtl/corr_host_bridge.sv
// Host byte-stream command decoder driving the correlator configuration and packet FIFO drain.
// Optional build macro CORR_HOST_BRIDGE_TIMEOUT_EN adds a write-data timeout in WRDATA.
module corr_host_bridge
    import corr_pkg::*;
#(
    parameter int         MAX_WINDOW_LENGTH_EXP = 16,
    parameter int         MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int         MAX_SAMPLE_JITTER_EXP = 8,
    parameter logic [7:0] ID_VALUE              = 8'hC0
`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
    , parameter int       TIMEOUT_W             = 20
`endif
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_cg,
    input  logic [7:0]                                  i_hostRx_data,
    input  logic                                        i_hostRx_valid,
    output logic                                        o_hostRx_ready,
    output logic [7:0]                                  o_hostTx_data,
    output logic                                        o_hostTx_valid,
    input  logic                                        i_hostTx_ready,
    output logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] o_windowLengthExp,
    output logic                                        o_windowShape,
    output logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] o_samplePeriodExp,
    output logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0] o_sampleJitterExp,
    output logic [2:0]                                  o_pwmSelect,
    output logic                                        o_wr_samplePeriod,
    output logic [7:0]                                  o_jitterSeedByte,
    output logic                                        o_jitterSeedValid,
    input  logic [7:0]                                  i_pktfifo_data,
    input  logic                                        i_pktfifo_empty,
    output logic                                        o_pktfifo_pop,
    output logic                                        o_pktfifo_flush
);

    localparam int WLW = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam int SPW = $clog2(MAX_SAMPLE_PERIOD_EXP + 1);
    localparam int SJW = $clog2(MAX_SAMPLE_JITTER_EXP + 1);

    corrState_t state;
    logic [6:0] addrReg;
    logic [7:0] txByte;
    logic [8:0] burstCnt;
    logic       wrSamplePeriodReg;
    logic       seedValidReg;
    logic       flushReg;
    logic [7:0] readData;
    logic       rxFire;
    logic       txFire;
    logic       singlePop;
`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeoutCnt;
`endif

    assign o_hostRx_ready = i_cg && (state == IDLE || state == WRDATA);
    assign o_hostTx_valid = i_cg && ((state == RDRESP) || (state == BURST && !i_pktfifo_empty));
    assign o_hostTx_data  = (state == BURST) ? i_pktfifo_data : txByte;
    assign rxFire         = i_hostRx_valid && o_hostRx_ready;
    assign txFire         = o_hostTx_valid && i_hostTx_ready;

    // Single-byte FIFO read pops in the same cycle the read command is taken.
    assign singlePop = (state == IDLE) && rxFire && !i_hostRx_data[7]
                       && (i_hostRx_data[6:0] == CORR_ADDR_FIFO) && !i_pktfifo_empty;
    assign o_pktfifo_pop = singlePop || ((state == BURST) && txFire);

    assign o_wr_samplePeriod = wrSamplePeriodReg && i_cg;
    assign o_jitterSeedValid = seedValidReg && i_cg;
    assign o_pktfifo_flush   = flushReg && i_cg;

    always_comb begin
        readData = 8'h00;
        case (i_hostRx_data[6:0])
            CORR_ADDR_WLEN:    readData = 8'(o_windowLengthExp);
            CORR_ADDR_WSHAPE:  readData = 8'(o_windowShape);
            CORR_ADDR_SPERIOD: readData = 8'(o_samplePeriodExp);
            CORR_ADDR_SJITTER: readData = 8'(o_sampleJitterExp);
            CORR_ADDR_PWM:     readData = 8'(o_pwmSelect);
            CORR_ADDR_FIFO:    readData = i_pktfifo_empty ? 8'h00 : i_pktfifo_data;
            CORR_ADDR_FLUSH:   readData = {7'b0, !i_pktfifo_empty};
            CORR_ADDR_ID:      readData = ID_VALUE;
            default:           readData = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            addrReg           <= '0;
            txByte            <= '0;
            burstCnt          <= '0;
            wrSamplePeriodReg <= 1'b0;
            seedValidReg      <= 1'b0;
            flushReg          <= 1'b0;
            o_windowLengthExp <= WLW'(RST_WINDOW_LENGTH_EXP);
            o_windowShape     <= 1'b0;
            o_samplePeriodExp <= SPW'(RST_SAMPLE_PERIOD_EXP);
            o_sampleJitterExp <= SJW'(RST_SAMPLE_JITTER_EXP);
            o_pwmSelect       <= '0;
            o_jitterSeedByte  <= '0;
`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
            timeoutCnt        <= '0;
`endif
        end else if (i_cg) begin
            wrSamplePeriodReg <= 1'b0;
            seedValidReg      <= 1'b0;
            flushReg          <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxFire) begin
                        addrReg <= i_hostRx_data[6:0];
`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
                        timeoutCnt <= '0;
`endif
                        if (i_hostRx_data[7]) begin
                            state <= WRDATA;
                        end else begin
                            txByte <= readData;
                            state  <= RDRESP;
                        end
                    end
                end
                WRDATA: begin
                    if (rxFire) begin
                        state <= IDLE;
                        case (addrReg)
                            CORR_ADDR_SEED: begin
                                o_jitterSeedByte <= i_hostRx_data;
                                seedValidReg     <= 1'b1;
                            end
                            CORR_ADDR_WLEN:
                                o_windowLengthExp <= WLW'(clampByte(i_hostRx_data, MAX_WINDOW_LENGTH_EXP));
                            CORR_ADDR_WSHAPE:  o_windowShape <= i_hostRx_data[0];
                            CORR_ADDR_SPERIOD: begin
                                o_samplePeriodExp <= SPW'(clampByte(i_hostRx_data, MAX_SAMPLE_PERIOD_EXP));
                                wrSamplePeriodReg <= 1'b1;
                            end
                            CORR_ADDR_SJITTER:
                                o_sampleJitterExp <= SJW'(clampByte(i_hostRx_data, MAX_SAMPLE_JITTER_EXP));
                            CORR_ADDR_PWM:     o_pwmSelect <= i_hostRx_data[2:0];
                            CORR_ADDR_FLUSH:   flushReg <= 1'b1;
                            CORR_ADDR_BURST: begin
                                // A zero length byte requests a full 256-byte burst.
                                burstCnt <= {(i_hostRx_data == 8'h00), i_hostRx_data};
                                state    <= BURST;
                            end
                            default: ;
                        endcase
                    end
`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
                    else if (timeoutCnt == '1) begin
                        state <= IDLE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
`endif
                end
                RDRESP: begin
                    if (txFire) state <= IDLE;
                end
                BURST: begin
                    if (txFire) begin
                        burstCnt <= burstCnt - 9'd1;
                        if (burstCnt == 9'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_host_bridge.sv
// Directed + randomized bench for corr_host_bridge with a queue-based host/FIFO model.
// Define CORR_HOST_BRIDGE_TIMEOUT_EN to also exercise the write-data timeout.
module tb_corr_host_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cg = 1'b1;
    logic [7:0] rxData = 8'h00;
    logic       rxValid = 1'b0;
    logic       rxReady;
    logic [7:0] txData;
    logic       txValid;
    logic       hostTxReady = 1'b1;
    logic [4:0] windowLengthExp;
    logic       windowShape;
    logic [3:0] samplePeriodExp;
    logic [3:0] sampleJitterExp;
    logic [2:0] pwmSelect;
    logic       wrSamplePeriod;
    logic [7:0] seedByte;
    logic       seedValid;
    logic [7:0] fifoData = 8'h00;
    logic       fifoEmpty = 1'b1;
    logic       fifoPop;
    logic       fifoFlush;

    int checks = 0;
    int fails = 0;
    logic [7:0] fifoQ[$];
    logic [7:0] txLog[$];
    logic [7:0] seedLog[$];
    logic [7:0] spLog[$];
    logic [7:0] expQ[$];
    int popCount = 0;
    int flushCount = 0;
    logic popNow = 1'b0;
    logic flushNow = 1'b0;
    bit   randReady = 1'b0;
    logic fixedReady = 1'b1;
    int   model[8];

    always #5 clk = ~clk;

`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
    corr_host_bridge #(.TIMEOUT_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg),
        .i_hostRx_data(rxData), .i_hostRx_valid(rxValid), .o_hostRx_ready(rxReady),
        .o_hostTx_data(txData), .o_hostTx_valid(txValid), .i_hostTx_ready(hostTxReady),
        .o_windowLengthExp(windowLengthExp), .o_windowShape(windowShape),
        .o_samplePeriodExp(samplePeriodExp), .o_sampleJitterExp(sampleJitterExp),
        .o_pwmSelect(pwmSelect), .o_wr_samplePeriod(wrSamplePeriod),
        .o_jitterSeedByte(seedByte), .o_jitterSeedValid(seedValid),
        .i_pktfifo_data(fifoData), .i_pktfifo_empty(fifoEmpty),
        .o_pktfifo_pop(fifoPop), .o_pktfifo_flush(fifoFlush)
    );
`else
    corr_host_bridge dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg),
        .i_hostRx_data(rxData), .i_hostRx_valid(rxValid), .o_hostRx_ready(rxReady),
        .o_hostTx_data(txData), .o_hostTx_valid(txValid), .i_hostTx_ready(hostTxReady),
        .o_windowLengthExp(windowLengthExp), .o_windowShape(windowShape),
        .o_samplePeriodExp(samplePeriodExp), .o_sampleJitterExp(sampleJitterExp),
        .o_pwmSelect(pwmSelect), .o_wr_samplePeriod(wrSamplePeriod),
        .o_jitterSeedByte(seedByte), .o_jitterSeedValid(seedValid),
        .i_pktfifo_data(fifoData), .i_pktfifo_empty(fifoEmpty),
        .o_pktfifo_pop(fifoPop), .o_pktfifo_flush(fifoFlush)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void refreshFifo();
        fifoEmpty = (fifoQ.size() == 0);
        fifoData  = fifoEmpty ? 8'h00 : fifoQ[0];
    endfunction

    // Host-side ready driver.
    always @(negedge clk) hostTxReady = randReady ? 1'($urandom_range(0, 1)) : fixedReady;

    // Observe handshakes just before the active edge, when everything is settled.
    always @(negedge clk) begin
        #4;
        popNow   = fifoPop;
        flushNow = fifoFlush;
        if (txValid && hostTxReady && !rst) txLog.push_back(txData);
        if (fifoPop) begin
            popCount++;
            check("pop_nonempty", 32'(fifoEmpty), 32'd0);
        end
        if (seedValid) seedLog.push_back(seedByte);
        if (wrSamplePeriod) spLog.push_back(8'(samplePeriodExp));
        if (fifoFlush) flushCount++;
    end

    // Packet FIFO model reacts to pop/flush after the edge.
    always @(posedge clk) begin
        #1;
        if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
        if (flushNow) fifoQ.delete();
        refreshFifo();
    end

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) model[i] = 0;
        model[1] = 10;
    endfunction

    // Behavioural register model: saturate exponents, mask the narrow fields.
    function automatic void modelWrite(input int addr, input int data);
        case (addr)
            1: model[1] = (data > 16) ? 16 : data;
            2: model[2] = data % 2;
            3: model[3] = (data > 15) ? 15 : data;
            4: model[4] = (data > 8) ? 8 : data;
            5: model[5] = data % 8;
            default: ;
        endcase
    endfunction

    task automatic sendByte(input logic [7:0] b);
        int k;
        @(negedge clk);
        rxData = b;
        rxValid = 1'b1;
        k = 0;
        #1;
        while (!rxReady && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("rx_accept_timeout", 32'(k < 2000), 32'd1);
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic waitTx(input int n);
        int k;
        k = 0;
        while (txLog.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("tx_wait", 32'(txLog.size() >= n), 32'd1);
    endtask

    task automatic readReg(input logic [6:0] addr, input logic [7:0] exp, input string tag);
        int n;
        n = txLog.size();
        sendByte({1'b0, addr});
        waitTx(n + 1);
        if (txLog.size() > n) check(tag, 32'(txLog[n]), 32'(exp));
    endtask

    task automatic writeReg(input logic [6:0] addr, input logic [7:0] data);
        sendByte({1'b1, addr});
        sendByte(data);
        repeat (2) @(negedge clk);
    endtask

    task automatic pushFifo(input logic [7:0] b);
        fifoQ.push_back(b);
        refreshFifo();
    endtask

    task automatic checkRegs(input string tag);
        check({tag, "_wlen"}, 32'(windowLengthExp), 32'(model[1]));
        check({tag, "_shape"}, 32'(windowShape), 32'(model[2]));
        check({tag, "_sper"}, 32'(samplePeriodExp), 32'(model[3]));
        check({tag, "_sjit"}, 32'(sampleJitterExp), 32'(model[4]));
        check({tag, "_pwm"}, 32'(pwmSelect), 32'(model[5]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int a, d, p0, f0;
        modelReset();
        refreshFifo();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_rx_ready", 32'(rxReady), 32'd1);
        check("rst_tx_valid", 32'(txValid), 32'd0);
        check("rst_pop", 32'(fifoPop), 32'd0);
        check("rst_pulses", 32'({seedValid, wrSamplePeriod, fifoFlush}), 32'd0);
        checkRegs("rst");

        // Clock gate forces handshakes low
        @(negedge clk);
        cg = 1'b0;
        #1;
        check("cg_rx_ready", 32'(rxReady), 32'd0);
        @(negedge clk);
        cg = 1'b1;

        // Basic reads
        readReg(7'h01, 8'h0A, "read_wlen_reset");
        readReg(7'h7F, 8'hC0, "read_id");
        readReg(7'h00, 8'h00, "read_seed");
        readReg(7'h08, 8'h00, "read_burst");
        readReg(7'h55, 8'h00, "read_unmapped");

        // Directed writes with clamp and pulse alignment
        spLog.delete();
        writeReg(7'h03, 8'h05);
        modelWrite(3, 5);
        check("sp_pulse_count", 32'(spLog.size()), 32'd1);
        if (spLog.size() > 0) check("sp_pulse_value", 32'(spLog[0]), 32'd5);
        writeReg(7'h01, 8'hFF);
        modelWrite(1, 255);
        check("wlen_clamp", 32'(windowLengthExp), 32'd16);
        writeReg(7'h55, 8'h12);
        checkRegs("after_unmapped_write");

        // Randomized register writes against the model
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(1, 5);
            d = $urandom_range(0, 255);
            writeReg(7'(a), 8'(d));
            modelWrite(a, d);
        end
        checkRegs("rand");
        for (int i = 1; i <= 5; i++) readReg(7'(i), 8'(model[i]), "rand_readback");

        // Seed strobes
        seedLog.delete();
        writeReg(7'h00, 8'h11);
        writeReg(7'h00, 8'h22);
        check("seed_count", 32'(seedLog.size()), 32'd2);
        if (seedLog.size() == 2) begin
            check("seed_0", 32'(seedLog[0]), 32'h11);
            check("seed_1", 32'(seedLog[1]), 32'h22);
        end

        // Burst with stall and random back-pressure
        txLog.delete();
        expQ.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            pushFifo(b);
            expQ.push_back(b);
        end
        p0 = popCount;
        randReady = 1'b1;
        writeReg(7'h08, 8'd5);
        waitTx(3);
        repeat (20) @(negedge clk);
        check("burst_stall_count", 32'(txLog.size()), 32'd3);
        #1;
        check("burst_stall_rx_ready", 32'(rxReady), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            pushFifo(b);
            expQ.push_back(b);
        end
        waitTx(5);
        for (int i = 0; i < 5; i++)
            if (i < txLog.size()) check("burst_byte", 32'(txLog[i]), 32'(expQ[i]));
        repeat (4) @(negedge clk);
        #1;
        check("burst_done_idle", 32'(rxReady), 32'd1);
        check("burst_pop_count", 32'(popCount - p0), 32'd5);
        randReady = 1'b0;

        // Single FIFO reads, status and flush
        p0 = popCount;
        readReg(7'h06, 8'h00, "fifo_read_empty");
        check("fifo_empty_no_pop", 32'(popCount - p0), 32'd0);
        readReg(7'h07, 8'h00, "status_empty");
        @(negedge clk);
        b = 8'($urandom);
        pushFifo(b);
        readReg(7'h07, 8'h01, "status_nonempty");
        readReg(7'h06, b, "fifo_read_byte");
        check("fifo_single_pop", 32'(popCount - p0), 32'd1);
        check("fifo_drained", 32'(fifoQ.size()), 32'd0);
        @(negedge clk);
        pushFifo(8'hA5);
        pushFifo(8'h5A);
        f0 = flushCount;
        writeReg(7'h07, 8'h00);
        check("flush_pulse_count", 32'(flushCount - f0), 32'd1);
        check("flush_emptied", 32'(fifoQ.size()), 32'd0);

        // Reset mid-burst
        writeReg(7'h01, 8'd3);
        writeReg(7'h05, 8'd6);
        @(negedge clk);
        pushFifo(8'h01);
        pushFifo(8'h02);
        writeReg(7'h08, 8'd10);
        repeat (10) @(negedge clk);
        fixedReady = 1'b0;
        repeat (2) @(negedge clk);
        pushFifo(8'h03);
        pushFifo(8'h04);
        p0 = popCount;
        #1;
        check("midburst_tx_valid", 32'(txValid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        modelReset();
        check("rst_burst_pop", 32'(fifoPop), 32'd0);
        check("rst_burst_tx_valid", 32'(txValid), 32'd0);
        check("rst_burst_rx_ready", 32'(rxReady), 32'd1);
        checkRegs("rst_burst");
        rst = 1'b0;
        fixedReady = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_burst_no_drain", 32'(popCount - p0), 32'd0);
        check("rst_burst_fifo_kept", 32'(fifoQ.size()), 32'd2);

`ifdef CORR_HOST_BRIDGE_TIMEOUT_EN
        // Abandoned write times out; the next byte is a command again
        sendByte(8'h81);
        repeat (80) @(negedge clk);
        readReg(7'h01, 8'h0A, "timeout_next_is_cmd");
        check("timeout_wlen_unchanged", 32'(windowLengthExp), 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
